xadc_scan_pwm: RTL and testbench

Parametrised XADC DRP round-robin scanner with per-channel optional averaging and per-channel PWM brightness outputs. It sits between `xadc_wiz_0` and downstream consumers (`transferFunction`, LEDs). It drives the DRP read side, captures the upper `DATA_W` bits of each configured channel, and adds what the single-channel path lacks: N channels, a per-channel address table, power-of-two averaging, DRP timeout detection, sample-valid strobes and glitch-free registered PWM.

---
 rtl/xadc_scan_pkg.sv | 17 +
 rtl/xadc_scan_pwm_pwm_bank.sv | 40 ++++
 rtl/xadc_scan_pwm.sv | 165 ++++++++++++++++
 tb/tb_xadc_scan_pwm.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/xadc_scan_pkg.sv
// Shared types and constants for the XADC DRP round-robin scanner.
package xadc_scan_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_EOC  = 2'd0,
    ST_REQ       = 2'd1,
    ST_WAIT_DRDY = 2'd2
  } scan_state_e;

  localparam logic [6:0] VAUX6  = 7'h16;
  localparam logic [6:0] VAUX7  = 7'h17;
  localparam logic [6:0] VAUX14 = 7'h1E;
  localparam logic [6:0] VAUX15 = 7'h1F;

  localparam int DRP_DATA_W = 16;

endpackage

// File: rtl/xadc_scan_pwm_pwm_bank.sv
// Per-channel PWM: free-running counter, duty latched at counter zero, registered compare.
module pwm_bank #(
  parameter int NUM_CH = 4,
  parameter int PWM_W  = 8
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NUM_CH-1:0][PWM_W-1:0]  duty_in,
  output logic [NUM_CH-1:0]             pwm_out
);

  logic [PWM_W-1:0]              cnt_q, cnt_d;
  logic [NUM_CH-1:0][PWM_W-1:0]  duty_q, duty_d;
  logic [NUM_CH-1:0]             pwm_q, pwm_d;

  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    // Duty only moves on the period boundary so a period never mixes two duties.
    duty_d = (cnt_q == '0) ? duty_in : duty_q;
    pwm_d  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pwm_d[i] = (cnt_q < duty_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q  <= '0;
      duty_q <= '0;
      pwm_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      duty_q <= duty_d;
      pwm_q  <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;

endmodule

// File: rtl/xadc_scan_pwm.sv
// Round-robin XADC DRP scanner with per-channel power-of-two averaging,
// DRP timeout detection, sample-valid strobes and per-channel PWM outputs.
module xadc_scan_pwm
  import xadc_scan_pkg::*;
#(
  parameter int                    NUM_CH   = 4,
  parameter logic [7*NUM_CH-1:0]   CH_ADDR  = {VAUX15, VAUX7, VAUX14, VAUX6},
  parameter int                    DATA_W   = 8,
  parameter int                    AVG_LOG2 = 0,
  parameter int                    PWM_W    = 8,
  parameter int                    TIMEOUT  = 255
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         xadc_eoc,
  output logic                         xadc_den,
  output logic [6:0]                   xadc_daddr,
  input  logic                         xadc_drdy,
  input  logic [DRP_DATA_W-1:0]        xadc_do,
  input  logic                         err_clr,
  output logic [NUM_CH*DATA_W-1:0]     data_out,
  output logic [NUM_CH-1:0]            data_valid,
  output logic                         timeout_err,
  output logic [NUM_CH-1:0]            pwm_out
);

  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PASS_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int ACC_W  = DATA_W + AVG_LOG2;
  localparam int TO_W   = $clog2(TIMEOUT);

  localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(NUM_CH - 1);
  localparam logic [PASS_W-1:0] PASS_MAX  = PASS_W'((1 << AVG_LOG2) - 1);
  // The counter is cleared on the edge leaving REQ, so it reads TIMEOUT-2 on the TIMEOUT-th edge after den.
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 2);

  scan_state_e                   state_q, state_d;
  logic [CH_W-1:0]               ch_idx_q, ch_idx_d;
  logic [PASS_W-1:0]             pass_q, pass_d;
  logic [TO_W-1:0]               to_cnt_q, to_cnt_d;
  logic                          den_q, den_d;
  logic [6:0]                    daddr_q, daddr_d;
  logic                          err_q, err_d;
  logic [NUM_CH-1:0][ACC_W-1:0]  acc_q, acc_d;
  logic [NUM_CH-1:0][DATA_W-1:0] dout_q, dout_d;
  logic [NUM_CH-1:0]             dv_q, dv_d;

  logic                          take;
  logic                          timed_out;
  logic [DATA_W-1:0]             sample;
  logic [ACC_W-1:0]              acc_sum;
  logic [NUM_CH-1:0][PWM_W-1:0]  duty_in;
  logic                          do_low_unused;

  assign do_low_unused = ^xadc_do[DRP_DATA_W-DATA_W-1:0];

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    state_d   = state_q;
    ch_idx_d  = ch_idx_q;
    pass_d    = pass_q;
    to_cnt_d  = to_cnt_q;
    err_d     = err_q & ~err_clr;
    acc_d     = acc_q;
    dout_d    = dout_q;
    dv_d      = '0;
    take      = 1'b0;
    timed_out = 1'b0;

    unique case (state_q)
      ST_WAIT_EOC: begin
        if (xadc_eoc) state_d = ST_REQ;
      end
      ST_REQ: begin
        to_cnt_d = '0;
        state_d  = ST_WAIT_DRDY;
      end
      ST_WAIT_DRDY: begin
        if (xadc_drdy) begin
          take = 1'b1;
        end else if (to_cnt_q == TO_LAST) begin
          take      = 1'b1;
          timed_out = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_WAIT_EOC;
    endcase

    // A timed-out read re-feeds the channel's last output so averages stay plausible.
    sample  = timed_out ? dout_q[ch_idx_q] : xadc_do[DRP_DATA_W-1 -: DATA_W];
    acc_sum = acc_q[ch_idx_q] + ACC_W'(sample);

    if (take) begin
      state_d = ST_WAIT_EOC;
      if (timed_out) err_d = 1'b1;
      if (pass_q == PASS_MAX) begin
        dout_d[ch_idx_q] = acc_sum[ACC_W-1 -: DATA_W];
        acc_d[ch_idx_q]  = '0;
        dv_d[ch_idx_q]   = 1'b1;
      end else begin
        acc_d[ch_idx_q]  = acc_sum;
      end
      if (ch_idx_q == LAST_CH) begin
        ch_idx_d = '0;
        pass_d   = (pass_q == PASS_MAX) ? '0 : pass_q + 1'b1;
      end else begin
        ch_idx_d = ch_idx_q + 1'b1;
      end
    end

    daddr_d = CH_ADDR[7*ch_idx_d +: 7];
    den_d   = (state_d == ST_REQ);

    for (int i = 0; i < NUM_CH; i++) begin
      duty_in[i] = dout_q[i][DATA_W-1 -: PWM_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= ST_WAIT_EOC;
      ch_idx_q <= '0;
      pass_q   <= '0;
      to_cnt_q <= '0;
      den_q    <= 1'b0;
      daddr_q  <= CH_ADDR[6:0];
      err_q    <= 1'b0;
      // NOTE: accumulators are plain registers, not RAM, so they take the reset like any other state.
      acc_q    <= '0;
      dout_q   <= '0;
      dv_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q  <= state_d;
      ch_idx_q <= ch_idx_d;
      pass_q   <= pass_d;
      to_cnt_q <= to_cnt_d;
      den_q    <= den_d;
      daddr_q  <= daddr_d;
      err_q    <= err_d;
      acc_q    <= acc_d;
      dout_q   <= dout_d;
      dv_q     <= dv_d;
    end
  end

  pwm_bank #(
    .NUM_CH (NUM_CH),
    .PWM_W  (PWM_W)
  ) u_pwm_bank (
    .clk     (clk),
    .resetn  (resetn),
    .duty_in (duty_in),
    .pwm_out (pwm_out)
  );

  assign xadc_den    = den_q;
  assign xadc_daddr  = daddr_q;
  assign data_out    = dout_q;
  assign data_valid  = dv_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_xadc_scan_pwm.sv
// Directed bench: a plain and an averaging scanner run in lockstep from one XADC model.
module tb_xadc_scan_pwm;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 8;
  localparam int PWM_W  = 8;
  localparam int TO     = 16;

  logic        clk = 1'b0;
  logic        resetn, eoc, drdy, err_clr;
  logic [15:0] xdo;

  logic                     den0, den1, err0, err1;
  logic [6:0]               daddr0, daddr1;
  logic [NUM_CH*DATA_W-1:0] dout0, dout1;
  logic [NUM_CH-1:0]        dv0, dv1, pwm0, pwm1;

  logic [15:0] xmem [0:127];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  xadc_scan_pwm #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .AVG_LOG2(0), .PWM_W(PWM_W), .TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn), .xadc_eoc(eoc), .xadc_den(den0), .xadc_daddr(daddr0),
    .xadc_drdy(drdy), .xadc_do(xdo), .err_clr(err_clr), .data_out(dout0),
    .data_valid(dv0), .timeout_err(err0), .pwm_out(pwm0));

  xadc_scan_pwm #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .AVG_LOG2(2), .PWM_W(PWM_W), .TIMEOUT(TO)) dut_avg (
    .clk(clk), .resetn(resetn), .xadc_eoc(eoc), .xadc_den(den1), .xadc_daddr(daddr1),
    .xadc_drdy(drdy), .xadc_do(xdo), .err_clr(err_clr), .data_out(dout1),
    .data_valid(dv1), .timeout_err(err1), .pwm_out(pwm1));

  // One conversion, called at a negedge with the scanner idle. lat = edge after den
  // on which drdy is sampled; lat = 0 withholds drdy for TO edges.
  task automatic conv(input int lat, input bit hold, output logic [6:0] addr,
                      output bit den_bad, output bit err_early);
    int last;
    last = (lat > 0) ? lat : TO;
    den_bad = 1'b0;
    err_early = 1'b0;
    eoc = 1'b1;
    @(negedge clk);
    if (!hold) eoc = 1'b0;
    addr = daddr0;
    if (den0 !== 1'b1) den_bad = 1'b1;
    for (int k = 1; k <= last; k++) begin
      if (k == lat) begin
        drdy = 1'b1;
        xdo  = xmem[addr];
      end
      @(negedge clk);
      drdy = 1'b0;
      if (den0 !== 1'b0) den_bad = 1'b1;
      if (k < last && err0 !== 1'b0) err_early = 1'b1;
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0; eoc = 1'b0; drdy = 1'b0; err_clr = 1'b0; xdo = '0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic run_pass(input logic [15:0] ch0_val);
    logic [6:0] a; bit db, ee;
    xmem[7'h16] = ch0_val;
    for (int i = 0; i < NUM_CH; i++) conv(3, 1'b0, a, db, ee);
  endtask

  task automatic count_high(input int n, output int highs);
    highs = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (pwm0[0] === 1'b1) highs++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (den0 !== 1'b0) begin errors++; $display("FAIL reset_den: got %b want 0", den0); end
    checks++; if (daddr0 !== 7'h16) begin errors++; $display("FAIL reset_daddr: got %h want 16", daddr0); end
    checks++; if (dout0 !== '0 || dout1 !== '0) begin errors++; $display("FAIL reset_dout: got %h/%h want 0", dout0, dout1); end
    checks++; if (dv0 !== '0 || err0 !== 1'b0 || pwm0 !== '0) begin
      errors++; $display("FAIL reset_flags: dv=%b err=%b pwm=%b want 0", dv0, err0, pwm0); end
  endtask

  task automatic test_scan();
    logic [6:0] seq [5] = '{7'h16, 7'h1E, 7'h17, 7'h1F, 7'h16};
    logic [6:0] a; bit db, ee;
    do_reset();
    xmem[7'h16] = 16'hAB00; xmem[7'h1E] = 16'h1200; xmem[7'h17] = 16'hFF00; xmem[7'h1F] = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      conv(3, 1'b0, a, db, ee);
      checks++; if (a !== seq[i]) begin errors++; $display("FAIL scan_daddr[%0d]: got %h want %h", i, a, seq[i]); end
      checks++; if (db) begin errors++; $display("FAIL scan_den[%0d]: den not a single pulse", i); end
      checks++; if (dv0 !== 4'(1 << (i % NUM_CH))) begin
        errors++; $display("FAIL scan_dv[%0d]: got %b want %b", i, dv0, 4'(1 << (i % NUM_CH))); end
      if (i == 3) begin
        checks++; if (dout0 !== 32'h00FF12AB) begin errors++; $display("FAIL scan_data: got %h want 00ff12ab", dout0); end
      end
    end
    @(negedge clk);
    checks++; if (dv0 !== '0 || err0 !== 1'b0) begin errors++; $display("FAIL scan_idle: dv=%b err=%b want 0", dv0, err0); end
  endtask

  task automatic test_average();
    logic [7:0] vals [4] = '{8'h10, 8'h20, 8'h30, 8'h41};
    logic [6:0] a; bit db, ee;
    do_reset();
    for (int p = 0; p < 4; p++) begin
      xmem[7'h16] = {vals[p], 8'h00};
      conv(3, 1'b0, a, db, ee);
      checks++; if (dv1[0] !== (p == 3)) begin errors++; $display("FAIL avg_dv[%0d]: got %b want %b", p, dv1[0], p == 3); end
      if (p == 3) begin
        checks++; if (dout1[7:0] !== 8'h28) begin errors++; $display("FAIL avg_value: got %h want 28", dout1[7:0]); end
        checks++; if (dout0[7:0] !== 8'h41) begin errors++; $display("FAIL avg_plain: got %h want 41", dout0[7:0]); end
      end
      for (int c = 1; c < NUM_CH; c++) conv(3, 1'b0, a, db, ee);
    end
  endtask

  task automatic test_timeout();
    logic [6:0] a; bit db, ee;
    do_reset();
    xmem[7'h16] = 16'hAB00; xmem[7'h1E] = 16'h1200; xmem[7'h17] = 16'hFF00; xmem[7'h1F] = 16'h0000;
    run_pass(16'hAB00);
    conv(3, 1'b0, a, db, ee);
    xmem[7'h1E] = 16'h5500;
    conv(0, 1'b0, a, db, ee);
    checks++; if (ee) begin errors++; $display("FAIL to_early: timeout_err rose before edge %0d", TO); end
    checks++; if (err0 !== 1'b1) begin errors++; $display("FAIL to_set: got %b want 1", err0); end
    checks++; if (dout0[15:8] !== 8'h12) begin errors++; $display("FAIL to_keep: got %h want 12", dout0[15:8]); end
    conv(3, 1'b0, a, db, ee);
    checks++; if (a !== 7'h17) begin errors++; $display("FAIL to_next: got %h want 17", a); end
    checks++; if (err0 !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b want 1", err0); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL to_clear: got %b want 0", err0); end
    conv(TO, 1'b0, a, db, ee);
    checks++; if (err0 !== 1'b0 || ee) begin errors++; $display("FAIL to_edge_drdy: err=%b early=%b want 0", err0, ee); end
    checks++; if (dv0 !== 4'b1000) begin errors++; $display("FAIL to_edge_capture: got %b want 1000", dv0); end
  endtask

  task automatic test_pwm();
    logic [6:0] a; bit db, ee;
    int h; bit found; logic prev;
    do_reset();
    run_pass(16'h0000);
    repeat (256) @(negedge clk);
    count_high(256, h);
    checks++; if (h != 0) begin errors++; $display("FAIL pwm_zero: got %0d want 0", h); end
    run_pass(16'h8000);
    repeat (256) @(negedge clk);
    count_high(256, h);
    checks++; if (h != 128) begin errors++; $display("FAIL pwm_half: got %0d want 128", h); end
    found = 1'b0;
    prev = pwm0[0];
    for (int i = 0; i < 600 && !found; i++) begin
      @(negedge clk);
      if (prev === 1'b1 && pwm0[0] === 1'b0) found = 1'b1;
      prev = pwm0[0];
    end
    checks++; if (!found) begin errors++; $display("FAIL pwm_fall: got none want falling edge"); end
    xmem[7'h16] = 16'hFF00;
    conv(3, 1'b0, a, db, ee);
    count_high(100, h);
    checks++; if (h != 0) begin errors++; $display("FAIL pwm_midperiod: got %0d want 0", h); end
    repeat (256) @(negedge clk);
    count_high(256, h);
    checks++; if (h != 255) begin errors++; $display("FAIL pwm_full: got %0d want 255", h); end
  endtask

  task automatic test_reset_mid();
    logic [6:0] a; bit db, ee;
    do_reset();
    xmem[7'h1E] = 16'h1200; xmem[7'h17] = 16'hFF00; xmem[7'h1F] = 16'h0000;
    run_pass(16'hAB00);
    conv(0, 1'b0, a, db, ee);
    eoc = 1'b1;
    @(negedge clk);
    eoc = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    drdy = 1'b1;
    xdo  = 16'hFFFF;
    @(negedge clk);
    drdy = 1'b0;
    checks++; if (den0 !== 1'b0 || dv0 !== '0 || err0 !== 1'b0) begin
      errors++; $display("FAIL mid_flags: den=%b dv=%b err=%b want 0", den0, dv0, err0); end
    checks++; if (dout0 !== '0 || dout1 !== '0 || pwm0 !== '0) begin
      errors++; $display("FAIL mid_data: dout=%h/%h pwm=%b want 0", dout0, dout1, pwm0); end
    checks++; if (daddr0 !== 7'h16) begin errors++; $display("FAIL mid_daddr: got %h want 16", daddr0); end
    conv(3, 1'b0, a, db, ee);
    checks++; if (a !== 7'h16 || dv0 !== 4'b0001) begin
      errors++; $display("FAIL mid_restart: addr=%h dv=%b want 16/0001", a, dv0); end
  endtask

  task automatic test_eoc_hold();
    logic [6:0] seq [3] = '{7'h16, 7'h1E, 7'h17};
    logic [6:0] a; bit db, ee;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      conv(3, 1'b1, a, db, ee);
      checks++; if (db || a !== seq[i]) begin
        errors++; $display("FAIL hold[%0d]: den_bad=%b addr=%h want 0/%h", i, db, a, seq[i]); end
    end
    eoc = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) xmem[i] = '0;
    test_reset();
    test_scan();
    test_average();
    test_timeout();
    test_pwm();
    test_reset_mid();
    test_eoc_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
